// File: rtl/arinc_pkg.sv
// Shared definitions for the ARINC-style RZ word transmitter.
//   arinc_state_e : transmitter FSM states
//   VEL_*         : rate codes carried on the VEL input
//   RATE_*        : line rates in bit/s
//   half_cycles() : clock cycles per half-bit for a given clock and rate
package arinc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } arinc_state_e;

    localparam logic [1:0] VEL_STOP = 2'b00;
    localparam logic [1:0] VEL_12K5 = 2'b01;
    localparam logic [1:0] VEL_50K  = 2'b10;
    localparam logic [1:0] VEL_100K = 2'b11;

    localparam int unsigned RATE_12K5 = 12_500;
    localparam int unsigned RATE_50K  = 50_000;
    localparam int unsigned RATE_100K = 100_000;

    // Truncating division: a clock that is not an exact multiple of the
    // rate simply runs slightly fast.
    function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                                input int unsigned rate);
        return clk_hz / (2 * rate);
    endfunction

endpackage

// File: rtl/arinc_baud.sv
// Half-bit timebase.
//   clk, srst : clock, synchronous active-high reset
//   restart   : force the count back to the start of a half-bit
//   run       : count while high, hold otherwise
//   vel       : latched rate code selecting the half-bit length
//   tick      : high on the last cycle of each half-bit
//   pre_tick  : high on the cycle before tick (lets the parent register
//               outputs that must coincide with tick)
// The clock must give at least two cycles per half-bit at the fastest rate
// for pre_tick to be meaningful.
module arinc_baud
    import arinc_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       restart,
    input  logic       run,
    input  logic [1:0] vel,
    output logic       tick,
    output logic       pre_tick
);

    localparam int unsigned HALF_SLOW = half_cycles(CLK_HZ, RATE_12K5);
    localparam int unsigned HALF_MID  = half_cycles(CLK_HZ, RATE_50K);
    localparam int unsigned HALF_FAST = half_cycles(CLK_HZ, RATE_100K);
    localparam int unsigned CW        = $clog2(HALF_SLOW + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] last_cnt;

    always_comb begin
        case (vel)
            VEL_50K:  last_cnt = CW'(HALF_MID - 1);
            VEL_100K: last_cnt = CW'(HALF_FAST - 1);
            default:  last_cnt = CW'(HALF_SLOW - 1);
        endcase
    end

    // >= rather than == so a count can never run past the terminal value.
    assign tick     = run && (cnt_reg >= last_cnt);
    assign pre_tick = run && ((cnt_reg + CW'(1)) == last_cnt);

    always_comb begin
        cnt_next = cnt_reg;
        if (restart) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = '0;
        end else if (run) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/arinc_tx.sv
// ARINC-style 32-bit return-to-zero word transmitter.
//   CLK, RST : clock, synchronous active-high reset
//   EN       : keep sending words while high
//   VEL      : rate code (00 stop, 01 12.5k, 10 50k, 11 100k)
//   ADR, DAT : label octet and 23-bit data field of the next word
//   TXP, TXN : RZ line pair; TXP pulses for '1', TXN for '0'
//   BUSY     : high from the load cycle to the end of the inter-word gap
//   DONE     : one-cycle pulse on the final cycle of the parity bit
// Line order: ADR[7..0], DAT[0..22], odd parity.
module arinc_tx
    import arinc_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [1:0]  VEL,
    input  logic [7:0]  ADR,
    input  logic [22:0] DAT,
    output logic        TXP,
    output logic        TXN,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned GAP_TICKS = 2 * GAP_BITS;
    localparam int unsigned GW        = $clog2(GAP_TICKS + 1);
    localparam logic [4:0]  LAST_BIT  = 5'd31;

    arinc_state_e  state_reg;
    logic [31:0]   word_reg;
    logic [31:0]   word_next;
    logic [22:0]   dat_rev;
    logic [1:0]    vel_reg;
    logic [4:0]    bit_cnt_reg;
    logic          half_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          txp_reg;
    logic          txn_reg;
    logic          done_reg;
    logic          tick;
    logic          pre_tick;
    logic          start_ok;
    logic          baud_run;
    logic          baud_restart;

    // Word is held in line order, MSB first, so bit n of the word on the
    // line is word_reg[31-n].
    genvar gi;
    generate
        for (gi = 0; gi < 23; gi++) begin : g_dat_rev
            assign dat_rev[22-gi] = DAT[gi];
        end
    endgenerate

    assign word_next = {ADR, dat_rev, ~^{ADR, DAT}};
    assign start_ok  = EN && (VEL != VEL_STOP);

    assign baud_run     = (state_reg == ST_SEND) || (state_reg == ST_GAP);
    assign baud_restart = !baud_run;

    arinc_baud #(
        .CLK_HZ(CLK_HZ)
    ) u_baud (
        .clk      (CLK),
        .srst     (RST),
        .restart  (baud_restart),
        .run      (baud_run),
        .vel      (vel_reg),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            word_reg    <= '0;
            vel_reg     <= VEL_STOP;
            bit_cnt_reg <= '0;
            half_reg    <= 1'b0;
            gap_cnt_reg <= '0;
            txp_reg     <= 1'b0;
            txn_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    word_reg    <= word_next;
                    vel_reg     <= VEL;
                    bit_cnt_reg <= '0;
                    half_reg    <= 1'b0;
                    // First half of ADR[7] is driven in the very next cycle.
                    txp_reg     <= word_next[31];
                    txn_reg     <= ~word_next[31];
                    state_reg   <= ST_SEND;
                end
                ST_SEND: begin
                    // DONE is registered, so it is armed one cycle ahead of
                    // the final tick of the parity bit.
                    if (half_reg && (bit_cnt_reg == LAST_BIT) && pre_tick) begin
                        done_reg <= 1'b1;
                    end
                    if (tick) begin
                        if (!half_reg) begin
                            half_reg <= 1'b1;
                            txp_reg  <= 1'b0;
                            txn_reg  <= 1'b0;
                        end else if (bit_cnt_reg == LAST_BIT) begin
                            half_reg    <= 1'b0;
                            bit_cnt_reg <= '0;
                            gap_cnt_reg <= '0;
                            state_reg   <= ST_GAP;
                        end else begin
                            half_reg    <= 1'b0;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            txp_reg     <= word_reg[5'd30 - bit_cnt_reg];
                            txn_reg     <= ~word_reg[5'd30 - bit_cnt_reg];
                        end
                    end
                end
                ST_GAP: begin
                    // The gap is counted in half-bits at the rate of the
                    // word that just finished.
                    if (tick) begin
                        if (gap_cnt_reg == GW'(GAP_TICKS - 1)) begin
                            gap_cnt_reg <= '0;
                            state_reg   <= start_ok ? ST_LOAD : ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + GW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign TXP  = txp_reg;
    assign TXN  = txn_reg;
    assign DONE = done_reg;
    assign BUSY = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_arinc_tx.sv
// Scoreboard bench for arinc_tx: the driver queues every word it expects on
// the line; an independent monitor rebuilds words from TXP/TXN and checks
// them against a reference model when DONE pulses.
module tb_arinc_tx;

    // Odd clock so the half-bit lengths exercise truncating division:
    // 100k -> 10, 50k -> 20, 12.5k -> 80 cycles.
    localparam int unsigned CLK_HZ   = 2_000_001;
    localparam int unsigned GAP_BITS = 4;
    localparam int          N_WORDS  = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [1:0]  VEL;
    logic [7:0]  ADR;
    logic [22:0] DAT;
    logic        TXP;
    logic        TXN;
    logic        BUSY;
    logic        DONE;

    arinc_tx #(
        .CLK_HZ   (CLK_HZ),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .VEL  (VEL),
        .ADR  (ADR),
        .DAT  (DAT),
        .TXP  (TXP),
        .TXN  (TXN),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  vel;
        logic [7:0]  adr;
        logic [22:0] dat;
    } word_t;

    word_t sb_q[$];
    int    n_cmp       = 0;
    int    n_fail      = 0;
    int    overlap_cnt = 0;
    int    word_cnt    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int half_of(input logic [1:0] v);
        case (v)
            2'b01:   return CLK_HZ / (2 * 12_500);
            2'b10:   return CLK_HZ / (2 * 50_000);
            default: return CLK_HZ / (2 * 100_000);
        endcase
    endfunction

    // Returns the 32 line bits, first bit transmitted in bit 31.
    function automatic logic [31:0] ref_word(input word_t w);
        logic [31:0] r;
        int          k;
        int          ones;
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            r[31-k] = w.adr[i];
            k++;
        end
        for (int j = 0; j < 23; j++) begin
            r[31-k] = w.dat[j];
            k++;
        end
        ones = $countones(w.adr) + $countones(w.dat);
        r[0] = ((ones % 2) == 0);
        return r;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w.vel = 2'($urandom_range(1, 3));
        w.adr = 8'($urandom);
        w.dat = 23'($urandom);
        return w;
    endfunction

    // ---------------- monitor ----------------
    int          mon_starts[32];
    int          mon_widths[32];
    logic [31:0] mon_rx;
    int          mon_nbits    = 0;
    bit          mon_in_pulse = 1'b0;
    int          mon_pstart   = 0;
    logic        mon_pval     = 1'b0;
    bit          mon_busy_prev = 1'b0;
    int          mon_load_cyc = -1000;
    int          cyc          = 0;

    initial begin : monitor
        word_t       e;
        int          h;
        int          terr;
        logic [31:0] exp_w;
        forever begin
            @(negedge CLK);
            cyc++;
            if (TXP && TXN) overlap_cnt++;
            if (RST) begin
                mon_nbits     = 0;
                mon_in_pulse  = 1'b0;
                mon_busy_prev = BUSY;
                continue;
            end
            if (BUSY && !mon_busy_prev) mon_load_cyc = cyc;
            mon_busy_prev = BUSY;

            if (mon_in_pulse && (!(TXP || TXN) || (TXP != mon_pval))) begin
                if (mon_nbits < 32) begin
                    mon_starts[mon_nbits] = mon_pstart;
                    mon_widths[mon_nbits] = cyc - mon_pstart;
                    mon_rx[31-mon_nbits]  = mon_pval;
                end
                mon_nbits++;
                mon_in_pulse = 1'b0;
            end
            if (!mon_in_pulse && (TXP ^ TXN)) begin
                mon_in_pulse = 1'b1;
                mon_pstart   = cyc;
                mon_pval     = TXP;
            end

            if (DONE) begin
                if (sb_q.size() == 0) begin
                    check("done_without_word", 1, 0);
                end else begin
                    e     = sb_q.pop_front();
                    h     = half_of(e.vel);
                    exp_w = ref_word(e);
                    check("bit_count", mon_nbits, 32);
                    if (mon_nbits == 32) begin
                        check("word_bits", mon_rx, exp_w);
                        terr = 0;
                        for (int k = 0; k < 32; k++) begin
                            if (mon_widths[k] != h) terr++;
                            if (k > 0 && (mon_starts[k] - mon_starts[k-1]) != 2 * h) terr++;
                        end
                        check("bit_timing_errors", terr, 0);
                        check("bit0_after_load", mon_starts[0] - mon_load_cyc, 1);
                        check("done_position", cyc - mon_starts[31], 2 * h - 1);
                    end
                    $display("word %0d: vel=%0d adr=%02h dat=%06h line=%08h expected=%08h bits=%0d",
                             word_cnt, e.vel, e.adr, e.dat, mon_rx, exp_w, mon_nbits);
                    word_cnt++;
                    // If BUSY stays high the next load follows the gap exactly.
                    mon_load_cyc = cyc + 2 * int'(GAP_BITS) * h + 1;
                end
                mon_nbits    = 0;
                mon_in_pulse = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (DONE) break;
        end
        check("done_seen", DONE, 1);
    endtask

    // Negedges from now until BUSY is sampled low.
    task automatic busy_fall_delay(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            n++;
            if (!BUSY) break;
        end
    endtask

    task automatic drive_word(input word_t w);
        ADR = w.adr;
        DAT = w.dat;
        VEL = w.vel;
        sb_q.push_back(w);
    endtask

    initial begin : driver
        word_t dir_tab[4];
        word_t w;
        int    h_fly;
        int    h_new;
        int    gap_n;
        int    dly;

        dir_tab[0] = '{vel: 2'b11, adr: 8'h84, dat: 23'h112200};
        dir_tab[1] = '{vel: 2'b11, adr: 8'h84, dat: 23'h110200};
        dir_tab[2] = '{vel: 2'b01, adr: 8'h3c, dat: 23'h5a5a5a};
        dir_tab[3] = '{vel: 2'b11, adr: 8'hc5, dat: 23'h00ff01};

        RST = 1'b1;
        EN  = 1'b0;
        VEL = 2'b00;
        ADR = '0;
        DAT = '0;
        cycles(3);
        check("rst_txp", TXP, 0);
        check("rst_txn", TXN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);

        RST = 1'b0;
        cycles(6);
        check("idle_without_en", BUSY, 0);

        // Continuous words; the next word's inputs are changed mid-flight
        // of the current one and must only take effect at the next load.
        drive_word(dir_tab[0]);
        EN    = 1'b1;
        h_fly = half_of(dir_tab[0].vel);
        cycles(3 + $urandom_range(0, 60 * h_fly));
        for (int k = 1; k < N_WORDS; k++) begin
            w = (k < 4) ? dir_tab[k] : rand_word();
            drive_word(w);
            h_new = half_of(w.vel);
            wait_done(100 * h_fly + 20);
            gap_n = 2 * int'(GAP_BITS) * h_fly;
            h_fly = h_new;
            cycles(gap_n + 2 + $urandom_range(0, 60 * h_fly));
        end

        // Rate code forced to stop mid-word: word finishes, FSM idles.
        VEL = 2'b00;
        wait_done(100 * h_fly + 20);
        busy_fall_delay(20 * h_fly + 20, dly);
        check("vel0_busy_fall_delay", dly, 2 * int'(GAP_BITS) * h_fly + 1);
        cycles(10);
        check("vel0_stays_idle", BUSY, 0);

        // EN dropped around bit 10: word and gap complete, then idle.
        w = rand_word();
        drive_word(w);
        h_fly = half_of(w.vel);
        cycles(2 + 20 * h_fly + h_fly / 2);
        EN = 1'b0;
        wait_done(100 * h_fly + 20);
        busy_fall_delay(20 * h_fly + 20, dly);
        check("en_drop_busy_fall_delay", dly, 2 * int'(GAP_BITS) * h_fly + 1);
        cycles(10);
        check("en_drop_stays_idle", BUSY, 0);

        // Reset around bit 20, then a fresh word must start from ADR[7].
        EN = 1'b1;
        w  = rand_word();
        drive_word(w);
        h_fly = half_of(w.vel);
        cycles(2 + 40 * h_fly + h_fly / 2);
        check("busy_before_reset", BUSY, 1);
        RST = 1'b1;
        cycles(1);
        check("rst_mid_txp", TXP, 0);
        check("rst_mid_txn", TXN, 0);
        check("rst_mid_busy", BUSY, 0);
        void'(sb_q.pop_back());
        cycles(2);
        w = rand_word();
        drive_word(w);
        h_fly = half_of(w.vel);
        RST = 1'b0;
        wait_done(100 * h_fly + 20);
        EN = 1'b0;
        busy_fall_delay(20 * h_fly + 20, dly);
        check("final_busy_fall_delay", dly, 2 * int'(GAP_BITS) * h_fly + 1);

        check("txp_txn_overlap_cycles", overlap_cnt, 0);
        check("scoreboard_left", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
